rs_issue_sched: RTL and testbench
=================================

Name: rs_issue_sched

Overview:
- Reservation-station entry manager and issue scheduler for one functional-unit RS.
- Accepts up to two in-order dispatches per cycle into free slots and tracks operand readiness through writeback tag broadcast.
- Selects the oldest fully-ready entry into a registered issue stage with a valid/ready handshake.
- Sits between the dispatch stage and the functional unit.

Parameters:
- RS_SIZE, 4, number of entries.
- RS_INDEX_WIDTH, 2, width of an entry index (log2 RS_SIZE).
- TAG_WIDTH, 6, physical register tag width.
- PAYLOAD_WIDTH, 64, opaque micro-op payload width.

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- flush_i in 1: pipeline flush.
- disp0_valid_i / disp1_valid_i in 1: dispatch lane request.
- disp0_ready_o / disp1_ready_o out 1: lane can be accepted.
- disp0_src_tag_i / disp1_src_tag_i in 2*TAG_WIDTH: src1 tag in the upper half, src0 tag in the lower half.
- disp0_src_rdy_i / disp1_src_rdy_i in 2: operand already available.
- disp0_payload_i / disp1_payload_i in PAYLOAD_WIDTH: micro-op payload.
- wb_valid_i in 1, wb_tag_i in TAG_WIDTH: writeback wakeup broadcast.
- issue_valid_o out 1: issue register holds a micro-op.
- issue_ready_i in 1: FU accepts.
- issue_payload_o out PAYLOAD_WIDTH: issued payload.
- issue_index_o out RS_INDEX_WIDTH: entry the micro-op came from.
- rs_unused_o out RS_SIZE: free-slot mask (1 = free).
- rs_count_o out RS_INDEX_WIDTH+1: number of occupied entries.

Behaviour:
- Reset values: all entries invalid; rs_unused_o all ones; rs_count_o=0; issue_valid_o=0; issue_payload_o=0; issue_index_o=0.
- Dispatch ready outputs are combinational from the registered free mask only. Slots freed this cycle become usable next cycle.
  - disp0_ready_o = at least one free slot.
  - disp1_ready_o = at least two free slots.
- Slot choice: lane0 takes the lowest free index, lane1 the second-lowest.
- disp1_valid_i without disp0_valid_i is illegal (in-order dispatch); flagged by assertion, and lane1 is ignored.
- Age: RS_SIZE x RS_SIZE age matrix. A new entry is younger than all valid entries. Lane1 is younger than lane0 in the same cycle.
- Wakeup: wb_valid_i with a tag match sets the matching operand ready bit at the next edge. This also applies to same-cycle dispatching operands (bypass), so no wakeup is lost.
- Entry ready = valid & both operand ready bits.
- Issue register loads when empty or firing (issue_valid_o & issue_ready_i):
  - Loads the oldest ready entry, selected from registered state.
  - The same edge clears that entry's valid bit.
  - If none is ready, it loads invalid.
- Latency: an entry ready in state at cycle N gives issue_valid_o at N+1. Dispatch with both operands ready gives issue at dispatch+2 at the earliest.
- Backpressure: while issue_valid_o & !issue_ready_i, issue_payload_o and issue_index_o are held stable and no entry is freed.
- Full: both ready outputs are 0, and dispatch attempts are ignored.
- rs_count_o is updated by +accepted dispatches and −1 for each entry moved into the issue register. Simultaneous dispatch and issue are netted in the same cycle.
- flush_i has priority over everything: at the next edge all entries are invalid, the issue register is empty, and same-cycle dispatches are dropped. Ready outputs are not masked by flush.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous).

Optional Feature:
- Macro RS_ISSUE_SCHED_PERF_EN.
- With the macro: adds output ports full_stall_cnt_o (32 bits, counts cycles with disp0_valid_i & !disp0_ready_o) and issue_stall_cnt_o (32 bits, counts cycles with issue_valid_o & !issue_ready_i).
  - Both counters saturate at all-ones.
  - Both reset to 0 and are not cleared by flush.
- Without the macro: the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package rs_sched_pkg holds:
  - the rs_entry_t struct (valid, src tag x2, src rdy x2, payload);
  - default width localparams;
  - a tag-match helper function.
- One sub-module, rs_age_select: combinational oldest-ready picker from the age matrix and ready vector, outputting a found flag and an index.

Test Plan:
- Reset, then dual dispatch with src_rdy=2'b11 and payloads 0xA/0xB → entries 0 and 1. issue_valid_o at +2 with index 0 and payload 0xA, then index 1 and payload 0xB on consecutive cycles with issue_ready_i=1.
- Four dispatches with unready tags 1–4 → rs_count_o=4 and disp0_ready_o=0. Then wb tag 3 wakes entry 2 only → issue index 2 two cycles later; disp0_ready_o=1 the cycle after the entry leaves.
- Fill entries in dispatch order 3,1,0,2 (after frees) all waiting on tag 9, then wb tag 9 → issue order follows dispatch age (3,1,0,2), not index order.
- issue_ready_i=0 for 3 cycles with issue_valid_o=1 → payload and index stable, rs_count_o unchanged; the fire on cycle 4 loads the next oldest.
- Dispatch src tag 7 unready in the same cycle as wb tag 7 → entry treated ready and issued at dispatch+2.
- Flush with 3 valid entries, a stalled issue register and a concurrent dual dispatch → next cycle rs_count_o=0, rs_unused_o=4'b1111, issue_valid_o=0.

Source files
------------

// File: rtl/rs_sched_pkg.sv
// Shared types and helpers for the reservation-station issue scheduler.
// Holds the entry record, default widths and the wakeup tag comparator.
package rs_sched_pkg;

   localparam int RS_SIZE_DEF        = 4;
   localparam int RS_INDEX_WIDTH_DEF = 2;
   localparam int TAG_WIDTH_DEF      = 6;
   localparam int PAYLOAD_WIDTH_DEF  = 64;

   typedef struct packed {
      logic                         valid;
      logic [TAG_WIDTH_DEF-1:0]     src1_tag;
      logic [TAG_WIDTH_DEF-1:0]     src0_tag;
      logic                         src1_rdy;
      logic                         src0_rdy;
      logic [PAYLOAD_WIDTH_DEF-1:0] payload;
   } rs_entry_t;

   function automatic logic tag_match(
      input logic                     wb_valid,
      input logic [TAG_WIDTH_DEF-1:0] wb_tag,
      input logic [TAG_WIDTH_DEF-1:0] src_tag
   );
      return wb_valid && (wb_tag == src_tag);
   endfunction

endpackage

// File: rtl/rs_age_select.sv
// Combinational oldest-ready picker: row i of the age matrix has bit j set
// when entry i is older than entry j.
module rs_age_select
   import rs_sched_pkg::*;
#(
   parameter int RS_SIZE        = RS_SIZE_DEF,
   parameter int RS_INDEX_WIDTH = RS_INDEX_WIDTH_DEF
) (
   input  logic [RS_SIZE-1:0]        i_age [RS_SIZE],
   input  logic [RS_SIZE-1:0]        i_ready,
   output logic                      o_found,
   output logic [RS_INDEX_WIDTH-1:0] o_index
);

   logic [RS_SIZE-1:0] w_oldest;

   // An entry wins when it is older than every other ready entry.
   genvar gi;
   generate
      for (gi = 0; gi < RS_SIZE; gi++) begin : g_oldest
         assign w_oldest[gi] = i_ready[gi] &
                               (&(i_age[gi] | ~i_ready | (RS_SIZE'(1) << gi)));
      end
   endgenerate

   always_comb begin
      o_found = |i_ready;
      o_index = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (w_oldest[i]) o_index = RS_INDEX_WIDTH'(i);
      end
   end

endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station entry manager with dual in-order dispatch, tag wakeup
// and oldest-ready issue. Optional stall counters: RS_ISSUE_SCHED_PERF_EN.
module rs_issue_sched
   import rs_sched_pkg::*;
#(
   parameter int RS_SIZE        = RS_SIZE_DEF,
   parameter int RS_INDEX_WIDTH = RS_INDEX_WIDTH_DEF,
   parameter int TAG_WIDTH      = TAG_WIDTH_DEF,
   parameter int PAYLOAD_WIDTH  = PAYLOAD_WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       disp0_valid_i,
   input  logic                       disp1_valid_i,
   output logic                       disp0_ready_o,
   output logic                       disp1_ready_o,
   input  logic [2*TAG_WIDTH-1:0]     disp0_src_tag_i,
   input  logic [2*TAG_WIDTH-1:0]     disp1_src_tag_i,
   input  logic [1:0]                 disp0_src_rdy_i,
   input  logic [1:0]                 disp1_src_rdy_i,
   input  logic [PAYLOAD_WIDTH-1:0]   disp0_payload_i,
   input  logic [PAYLOAD_WIDTH-1:0]   disp1_payload_i,
   input  logic                       wb_valid_i,
   input  logic [TAG_WIDTH-1:0]       wb_tag_i,
   output logic                       issue_valid_o,
   input  logic                       issue_ready_i,
   output logic [PAYLOAD_WIDTH-1:0]   issue_payload_o,
   output logic [RS_INDEX_WIDTH-1:0]  issue_index_o,
   output logic [RS_SIZE-1:0]         rs_unused_o,
   output logic [RS_INDEX_WIDTH:0]    rs_count_o
`ifdef RS_ISSUE_SCHED_PERF_EN
   ,
   output logic [31:0]                full_stall_cnt_o,
   output logic [31:0]                issue_stall_cnt_o
`endif
);

   logic [RS_SIZE-1:0]        w_valid, w_free, w_ready;
   logic [RS_SIZE-1:0]        w_alloc0, w_alloc1, w_take_mask;
   logic [RS_SIZE-1:0]        w_age [RS_SIZE];
   logic [PAYLOAD_WIDTH-1:0]  w_payload [RS_SIZE];
   logic [RS_INDEX_WIDTH-1:0] w_slot0, w_slot1, w_sel;
   logic                      w_has0, w_has1, w_found;
   logic                      w_acc0, w_acc1, w_load, w_take;
   rs_entry_t                 w_new0, w_new1;

   logic                      r_issue_valid;
   logic [PAYLOAD_WIDTH-1:0]  r_issue_payload;
   logic [RS_INDEX_WIDTH-1:0] r_issue_index;
   logic [RS_INDEX_WIDTH:0]   r_count;

   assign w_free = ~w_valid;

   always_comb begin
      w_has0  = 1'b0;
      w_has1  = 1'b0;
      w_slot0 = '0;
      w_slot1 = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (w_free[i]) begin
            if (!w_has0) begin
               w_has0  = 1'b1;
               w_slot0 = RS_INDEX_WIDTH'(i);
            end else if (!w_has1) begin
               w_has1  = 1'b1;
               w_slot1 = RS_INDEX_WIDTH'(i);
            end
         end
      end
   end

   assign disp0_ready_o = w_has0;
   assign disp1_ready_o = w_has1;

   // Lane1 is only honoured alongside lane0 so dispatch stays in order.
   assign w_acc0   = disp0_valid_i & w_has0 & ~flush_i;
   assign w_acc1   = disp0_valid_i & disp1_valid_i & w_has1 & ~flush_i;
   assign w_alloc0 = w_acc0 ? (RS_SIZE'(1) << w_slot0) : '0;
   assign w_alloc1 = w_acc1 ? (RS_SIZE'(1) << w_slot1) : '0;

   assign w_load      = ~r_issue_valid | issue_ready_i;
   assign w_take      = w_load & w_found & ~flush_i;
   assign w_take_mask = w_take ? (RS_SIZE'(1) << w_sel) : '0;

   // New entries also catch a writeback broadcast in their dispatch cycle.
   always_comb begin
      w_new0          = '0;
      w_new0.valid    = 1'b1;
      w_new0.src0_tag = disp0_src_tag_i[TAG_WIDTH-1:0];
      w_new0.src1_tag = disp0_src_tag_i[2*TAG_WIDTH-1:TAG_WIDTH];
      w_new0.src0_rdy = disp0_src_rdy_i[0] |
                        tag_match(wb_valid_i, wb_tag_i, disp0_src_tag_i[TAG_WIDTH-1:0]);
      w_new0.src1_rdy = disp0_src_rdy_i[1] |
                        tag_match(wb_valid_i, wb_tag_i, disp0_src_tag_i[2*TAG_WIDTH-1:TAG_WIDTH]);
      w_new0.payload  = disp0_payload_i;
      w_new1          = '0;
      w_new1.valid    = 1'b1;
      w_new1.src0_tag = disp1_src_tag_i[TAG_WIDTH-1:0];
      w_new1.src1_tag = disp1_src_tag_i[2*TAG_WIDTH-1:TAG_WIDTH];
      w_new1.src0_rdy = disp1_src_rdy_i[0] |
                        tag_match(wb_valid_i, wb_tag_i, disp1_src_tag_i[TAG_WIDTH-1:0]);
      w_new1.src1_rdy = disp1_src_rdy_i[1] |
                        tag_match(wb_valid_i, wb_tag_i, disp1_src_tag_i[2*TAG_WIDTH-1:TAG_WIDTH]);
      w_new1.payload  = disp1_payload_i;
   end

   genvar gi;
   generate
      for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
         rs_entry_t          r_entry;
         logic [RS_SIZE-1:0] r_age_row;

         // A fresh entry is older than nobody, except lane0 over lane1.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_entry   <= '0;
               r_age_row <= '0;
            end else if (flush_i) begin
               r_entry.valid <= 1'b0;
            end else if (w_alloc0[gi]) begin
               r_entry   <= w_new0;
               r_age_row <= w_alloc1;
            end else if (w_alloc1[gi]) begin
               r_entry   <= w_new1;
               r_age_row <= '0;
            end else begin
               r_age_row <= r_age_row | w_alloc0 | w_alloc1;
               if (w_take_mask[gi]) r_entry.valid <= 1'b0;
               if (tag_match(wb_valid_i, wb_tag_i, r_entry.src0_tag)) r_entry.src0_rdy <= 1'b1;
               if (tag_match(wb_valid_i, wb_tag_i, r_entry.src1_tag)) r_entry.src1_rdy <= 1'b1;
            end
         end

         assign w_valid[gi]   = r_entry.valid;
         assign w_ready[gi]   = r_entry.valid & r_entry.src0_rdy & r_entry.src1_rdy;
         assign w_age[gi]     = r_age_row;
         assign w_payload[gi] = r_entry.payload;
      end
   endgenerate

   rs_age_select #(
      .RS_SIZE        (RS_SIZE),
      .RS_INDEX_WIDTH (RS_INDEX_WIDTH)
   ) u_age_select (
      .i_age   (w_age),
      .i_ready (w_ready),
      .o_found (w_found),
      .o_index (w_sel)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_issue_valid   <= 1'b0;
         r_issue_payload <= '0;
         r_issue_index   <= '0;
      end else if (flush_i) begin
         r_issue_valid <= 1'b0;
      end else if (w_load) begin
         r_issue_valid <= w_found;
         if (w_found) begin
            r_issue_payload <= w_payload[w_sel];
            r_issue_index   <= w_sel;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_count <= '0;
      else if (flush_i) r_count <= '0;
      else              r_count <= r_count + (RS_INDEX_WIDTH+1)'(w_acc0)
                                           + (RS_INDEX_WIDTH+1)'(w_acc1)
                                           - (RS_INDEX_WIDTH+1)'(w_take);
   end

   assign issue_valid_o   = r_issue_valid;
   assign issue_payload_o = r_issue_payload;
   assign issue_index_o   = r_issue_index;
   assign rs_unused_o     = w_free;
   assign rs_count_o      = r_count;

`ifdef RS_ISSUE_SCHED_PERF_EN
   logic [31:0] r_full_stall_cnt, r_issue_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full_stall_cnt  <= '0;
         r_issue_stall_cnt <= '0;
      end else begin
         if (disp0_valid_i && !w_has0 && (r_full_stall_cnt != '1))
            r_full_stall_cnt <= r_full_stall_cnt + 32'd1;
         if (r_issue_valid && !issue_ready_i && (r_issue_stall_cnt != '1))
            r_issue_stall_cnt <= r_issue_stall_cnt + 32'd1;
      end
   end

   assign full_stall_cnt_o  = r_full_stall_cnt;
   assign issue_stall_cnt_o = r_issue_stall_cnt;
`endif

   a_inorder_dispatch: assert property (@(posedge clk) disable iff (rst)
      !(disp1_valid_i && !disp0_valid_i));

endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a sequence-number model.
module tb_rs_issue_sched;

   logic        clk, rst, flush;
   logic        d0v, d1v, d0rdy_o, d1rdy_o;
   logic [11:0] d0tag, d1tag;
   logic [1:0]  d0rdy, d1rdy;
   logic [63:0] d0pay, d1pay;
   logic        wbv, iready, iv;
   logic [5:0]  wbtag;
   logic [63:0] ipay;
   logic [1:0]  iidx;
   logic [3:0]  unused;
   logic [2:0]  cnt;
`ifdef RS_ISSUE_SCHED_PERF_EN
   logic [31:0] full_cnt, istall_cnt;
`endif

   rs_issue_sched dut (
      .clk             (clk),
      .rst             (rst),
      .flush_i         (flush),
      .disp0_valid_i   (d0v),
      .disp1_valid_i   (d1v),
      .disp0_ready_o   (d0rdy_o),
      .disp1_ready_o   (d1rdy_o),
      .disp0_src_tag_i (d0tag),
      .disp1_src_tag_i (d1tag),
      .disp0_src_rdy_i (d0rdy),
      .disp1_src_rdy_i (d1rdy),
      .disp0_payload_i (d0pay),
      .disp1_payload_i (d1pay),
      .wb_valid_i      (wbv),
      .wb_tag_i        (wbtag),
      .issue_valid_o   (iv),
      .issue_ready_i   (iready),
      .issue_payload_o (ipay),
      .issue_index_o   (iidx),
      .rs_unused_o     (unused),
      .rs_count_o      (cnt)
`ifdef RS_ISSUE_SCHED_PERF_EN
      ,
      .full_stall_cnt_o  (full_cnt),
      .issue_stall_cnt_o (istall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Model: per-slot contents plus a dispatch sequence number for age.
   bit          mv [4];
   logic [5:0]  mt0 [4], mt1 [4];
   bit          mr0 [4], mr1 [4];
   logic [63:0] mp [4];
   int unsigned mseq [4];
   int unsigned seqctr;
   bit          miv;
   logic [63:0] mpay;
   int          midx;
   longint unsigned mfull, missue;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mv[i] = 0;
      miv = 0; mpay = '0; midx = 0; seqctr = 0; mfull = 0; missue = 0;
   endtask

   function automatic int nfree();
      int n = 0;
      for (int i = 0; i < 4; i++) if (!mv[i]) n++;
      return n;
   endfunction

   task automatic model_step();
      int fr[$];
      int p;
      bit a0, a1, load;
      for (int i = 0; i < 4; i++) if (!mv[i]) fr.push_back(i);
      a0 = d0v && fr.size() >= 1 && !flush;
      a1 = d0v && d1v && fr.size() >= 2 && !flush;
      if (d0v && fr.size() == 0 && mfull < 64'hFFFF_FFFF) mfull++;
      if (miv && !iready && missue < 64'hFFFF_FFFF) missue++;
      if (flush) begin
         for (int i = 0; i < 4; i++) mv[i] = 0;
         miv = 0;
         return;
      end
      load = !miv || iready;
      p = -1;
      for (int i = 0; i < 4; i++)
         if (mv[i] && mr0[i] && mr1[i] && (p < 0 || mseq[i] < mseq[p])) p = i;
      if (load) begin
         if (p >= 0) begin
            miv = 1; mpay = mp[p]; midx = p; mv[p] = 0;
         end else miv = 0;
      end
      for (int i = 0; i < 4; i++) if (mv[i] && wbv) begin
         if (mt0[i] == wbtag) mr0[i] = 1;
         if (mt1[i] == wbtag) mr1[i] = 1;
      end
      if (a0) begin
         mv[fr[0]] = 1; mt0[fr[0]] = d0tag[5:0]; mt1[fr[0]] = d0tag[11:6];
         mr0[fr[0]] = d0rdy[0] || (wbv && d0tag[5:0] == wbtag);
         mr1[fr[0]] = d0rdy[1] || (wbv && d0tag[11:6] == wbtag);
         mp[fr[0]] = d0pay; mseq[fr[0]] = seqctr++;
      end
      if (a1) begin
         mv[fr[1]] = 1; mt0[fr[1]] = d1tag[5:0]; mt1[fr[1]] = d1tag[11:6];
         mr0[fr[1]] = d1rdy[0] || (wbv && d1tag[5:0] == wbtag);
         mr1[fr[1]] = d1rdy[1] || (wbv && d1tag[11:6] == wbtag);
         mp[fr[1]] = d1pay; mseq[fr[1]] = seqctr++;
      end
   endtask

   task automatic check_all();
      logic [3:0] m;
      int nf = nfree();
      for (int i = 0; i < 4; i++) m[i] = !mv[i];
      chk("disp0_ready", d0rdy_o, 64'(nf >= 1));
      chk("disp1_ready", d1rdy_o, 64'(nf >= 2));
      chk("rs_unused", unused, m);
      chk("rs_count", cnt, 64'(4 - nf));
      chk("issue_valid", iv, miv);
      if (miv) begin
         chk("issue_payload", ipay, mpay);
         chk("issue_index", iidx, 64'(midx));
      end
`ifdef RS_ISSUE_SCHED_PERF_EN
      chk("full_stall_cnt", full_cnt, mfull);
      chk("issue_stall_cnt", istall_cnt, missue);
`endif
   endtask

   task automatic set_idle();
      flush = 0; d0v = 0; d1v = 0; d0tag = '0; d1tag = '0; d0rdy = 0; d1rdy = 0;
      d0pay = '0; d1pay = '0; wbv = 0; wbtag = '0; iready = 1;
   endtask

   task automatic step();
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic flush_step();
      set_idle(); flush = 1; step(); set_idle();
   endtask

   task automatic disp_one(input logic [5:0] tag0, input logic [63:0] pay);
      set_idle(); d0v = 1; d0tag = {6'd0, tag0}; d0rdy = 2'b10; d0pay = pay; step(); set_idle();
   endtask

   task automatic wb_step(input logic [5:0] tag);
      set_idle(); wbv = 1; wbtag = tag; step(); set_idle();
   endtask

   task automatic rand_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         flush  = ($urandom_range(0, 49) == 0);
         d0v    = $urandom_range(0, 1) == 1;
         d1v    = d0v && ($urandom_range(0, 1) == 1);
         d0tag  = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
         d1tag  = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
         d0rdy  = 2'($urandom_range(0, 3));
         d1rdy  = 2'($urandom_range(0, 3));
         d0pay  = {$urandom, $urandom};
         d1pay  = {$urandom, $urandom};
         wbv    = $urandom_range(0, 1) == 1;
         wbtag  = 6'($urandom_range(0, 7));
         iready = $urandom_range(0, 9) < 7;
         step();
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      rst = 1;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_unused", unused, 64'hF);
      chk("reset_count", cnt, 0);
      chk("reset_issue_valid", iv, 0);
      chk("reset_issue_payload", ipay, 0);
      chk("reset_issue_index", iidx, 0);
      rst = 0;
      @(negedge clk);
      check_all();

      // Dual dispatch of ready ops issues at +2 in lane order.
      d0v = 1; d1v = 1; d0rdy = 2'b11; d1rdy = 2'b11; d0pay = 64'hA; d1pay = 64'hB;
      step(); set_idle();
      chk("dual_count", cnt, 2);
      chk("dual_iv_early", iv, 0);
      step();
      chk("dual_iv0", iv, 1); chk("dual_idx0", iidx, 0); chk("dual_pay0", ipay, 64'hA);
      chk("dual_count1", cnt, 1);
      step();
      chk("dual_idx1", iidx, 1); chk("dual_pay1", ipay, 64'hB);
      step();
      chk("dual_drained", iv, 0);

      // Fill with unready tags 1..4, wake tag 3 only.
      flush_step();
      d0v = 1; d1v = 1; d0rdy = 2'b10; d1rdy = 2'b10; d0tag = 12'd1; d1tag = 12'd2;
      step();
      d0tag = 12'd3; d1tag = 12'd4;
      step(); set_idle();
      chk("full_count", cnt, 4);
      chk("full_ready0", d0rdy_o, 0);
      wb_step(6'd3);
      chk("wake_iv_early", iv, 0);
      step();
      chk("wake_iv", iv, 1); chk("wake_idx", iidx, 2);
      chk("wake_count", cnt, 3); chk("wake_ready0", d0rdy_o, 1);
      step();

      // Age order 3,1,0,2 after frees, all released by tag 9.
      flush_step();
      d0v = 1; d1v = 1; d0rdy = 2'b10; d1rdy = 2'b10; d0tag = 12'd20; d1tag = 12'd21;
      step();
      d0tag = 12'd22; d1tag = 12'd9; d0pay = 64'h32; d1pay = 64'h33;
      step(); set_idle();
      wb_step(6'd21); step(); disp_one(6'd9, 64'h31);
      wb_step(6'd20); step(); disp_one(6'd9, 64'h30);
      wb_step(6'd22); step(); disp_one(6'd9, 64'h32);
      wb_step(6'd9);
      step(); chk("age_idx_a", iidx, 3);
      step(); chk("age_idx_b", iidx, 1);
      step(); chk("age_idx_c", iidx, 0);
      step(); chk("age_idx_d", iidx, 2);

      // Backpressure holds the issue register for three cycles.
      flush_step();
      iready = 0; d0v = 1; d1v = 1; d0rdy = 2'b11; d1rdy = 2'b11;
      d0pay = 64'h41; d1pay = 64'h42;
      step(); set_idle(); iready = 0;
      step();
      chk("bp_iv", iv, 1); chk("bp_idx", iidx, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("bp_hold_idx", iidx, 0); chk("bp_hold_pay", ipay, 64'h41); chk("bp_hold_cnt", cnt, 1);
      end
      iready = 1;
      step();
      chk("bp_next_idx", iidx, 1); chk("bp_next_pay", ipay, 64'h42);
      step();

      // Same-cycle wakeup of a dispatching operand.
      flush_step();
      d0v = 1; d0tag = 12'd7; d0rdy = 2'b10; d0pay = 64'h77; wbv = 1; wbtag = 6'd7;
      step(); set_idle();
      step();
      chk("bypass_iv", iv, 1); chk("bypass_pay", ipay, 64'h77);

      // Flush with three waiting entries, a stalled issue and a dispatch.
      flush_step();
      d0v = 1; d1v = 1; d0rdy = 2'b11; d1rdy = 2'b10; d0pay = 64'h61; d1tag = 12'd30;
      step();
      d0rdy = 2'b10; d0tag = 12'd31; d1tag = 12'd32; iready = 0;
      step();
      chk("pre_flush_cnt", cnt, 3); chk("pre_flush_iv", iv, 1);
      set_idle(); iready = 0; flush = 1; d0v = 1; d1v = 1; d0rdy = 2'b11; d1rdy = 2'b11;
      step(); set_idle();
      chk("flush_cnt", cnt, 0); chk("flush_unused", unused, 64'hF); chk("flush_iv", iv, 0);

      rand_cycles(3000);

      // Asynchronous reset between edges.
      #3 rst = 1;
      #1;
      chk("async_rst_iv", iv, 0);
      chk("async_rst_cnt", cnt, 0);
      chk("async_rst_unused", unused, 64'hF);
      model_reset();
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      check_all();
      rand_cycles(1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
